frogger_game_fsm: RTL and testbench

Top-level game sequencer for the Frogger design. It owns the game state (title, playing, death, level-up, game over), lives, level, round timer and home-count. It drives the enable, respawn and score-clear strobes that gate the frog controller and obstacle lanes. It sits between the debounced switch inputs and frog/collision logic on one side, and the VGA overlay (lives/time/level digits) on the other.

---
 rtl/frogger_pkg.sv | 26 ++
 rtl/frogger_tick_gen.sv | 46 ++++
 rtl/frogger_game_fsm.sv | 189 ++++++++++++++++++
 tb/tb_frogger_game_fsm.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Shared Frogger definitions: game state encoding, playfield geometry and
// default timing constants used by the game sequencer and its helpers.
package frogger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_DEATH     = 3'd2,
    ST_LEVEL_UP  = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_e;

  // Playfield is a 20 x 15 tile grid; the frog respawns at tile (10,14).
  localparam int c_GRID_W   = 20;
  localparam int c_GRID_H   = 15;
  localparam int c_ORIGIN_X = 10;
  localparam int c_ORIGIN_Y = 14;

  // One-second prescale at a 25 MHz pixel clock.
  localparam int c_CLKS_PER_SEC = 25000000;

  // Counter widths for the second prescaler and the freeze-hold counter.
  localparam int c_PRESCALE_W = 25;
  localparam int c_HOLD_W     = 24;

endpackage

// File: rtl/frogger_tick_gen.sv
// Parameterized prescaler: counts 0..p_COUNT-1 while enabled, wraps, and
// flags the terminal cycle with a one-cycle tick. A synchronous clear parks
// the count at zero so the next enabled period starts from a clean phase.
module frogger_tick_gen #(
  parameter int p_WIDTH = 25,
  parameter int p_COUNT = 25000000
) (
  input  logic clk_i,
  input  logic rst_l_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [p_WIDTH-1:0] c_TERM = p_WIDTH'(p_COUNT - 1);
  localparam logic [p_WIDTH-1:0] c_ONE  = p_WIDTH'(1);

  logic [p_WIDTH-1:0] count_q;
  logic [p_WIDTH-1:0] count_d;

  assign tick_o = en_i && !clear_i && (count_q == c_TERM);

  // Next count: clear has priority, otherwise advance and wrap at terminal.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      if (count_q == c_TERM) begin
        count_d = '0;
      end else begin
        count_d = count_q + c_ONE;
      end
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_l_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/frogger_game_fsm.sv
// Frogger game sequencer: title/play/death/level-up/game-over flow, lives,
// level, round timer and home count, plus the play enable and the respawn
// and score-clear strobes. Every output is registered.
module frogger_game_fsm #(
  parameter int c_CLKS_PER_SEC    = frogger_pkg::c_CLKS_PER_SEC,
  parameter int c_START_LIVES     = 3,
  parameter int c_ROUND_SECONDS   = 60,
  parameter int c_HOLD_CLKS       = 12500000,
  parameter int c_HOMES_PER_LEVEL = 5,
  parameter int c_MAX_LEVEL       = 7
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Start,
  input  logic       i_Collided,
  input  logic       i_Home_Pulse,
  output logic [2:0] o_Game_State,
  output logic       o_Play_En,
  output logic       o_Respawn,
  output logic       o_Score_Clear,
  output logic [1:0] o_Lives,
  output logic [2:0] o_Level,
  output logic [6:0] o_Time_Left
);

  import frogger_pkg::*;

  localparam int                  c_HOME_W       = $clog2(c_HOMES_PER_LEVEL + 1);
  localparam logic [1:0]          c_LIVES_INIT   = 2'(c_START_LIVES);
  localparam logic [6:0]          c_TIME_INIT    = 7'(c_ROUND_SECONDS);
  localparam logic [2:0]          c_LEVEL_MAX    = 3'(c_MAX_LEVEL);
  localparam logic [c_HOME_W-1:0] c_HOMES_TARGET = c_HOME_W'(c_HOMES_PER_LEVEL);
  localparam logic [c_HOME_W-1:0] c_HOME_ONE     = c_HOME_W'(1);

  game_state_e         state_q, state_d;
  logic [1:0]          lives_q, lives_d;
  logic [2:0]          level_q, level_d;
  logic [6:0]          time_q, time_d;
  logic [c_HOME_W-1:0] homes_q, homes_d;
  logic                respawn_q, respawn_d;
  logic                score_clr_q, score_clr_d;
  logic                play_en_q, play_en_d;
  logic                start_q;

  logic                start_edge;
  logic                sec_en, sec_tick;
  logic                hold_en, hold_tick;
  logic                death;
  logic [c_HOME_W-1:0] homes_inc;
  logic [6:0]          time_dec;

  assign start_edge = i_Start && !start_q;
  assign sec_en     = (state_q == ST_PLAY);
  assign hold_en    = (state_q == ST_DEATH) || (state_q == ST_LEVEL_UP);
  // A tick on the last second ends the round just like a collision does.
  assign death      = i_Collided || (sec_tick && (time_q == 7'd1));
  assign homes_inc  = homes_q + c_HOME_ONE;
  assign time_dec   = (time_q != 7'd0) ? (time_q - 7'd1) : time_q;

  frogger_tick_gen #(
    .p_WIDTH (c_PRESCALE_W),
    .p_COUNT (c_CLKS_PER_SEC)
  ) u_sec_tick (
    .clk_i   (i_Clk),
    .rst_l_i (i_Rst_L),
    .clear_i (!sec_en),
    .en_i    (sec_en),
    .tick_o  (sec_tick)
  );

  frogger_tick_gen #(
    .p_WIDTH (c_HOLD_W),
    .p_COUNT (c_HOLD_CLKS)
  ) u_hold_tick (
    .clk_i   (i_Clk),
    .rst_l_i (i_Rst_L),
    .clear_i (!hold_en),
    .en_i    (hold_en),
    .tick_o  (hold_tick)
  );

  // Next-state and next-output logic for the game flow.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    level_d     = level_q;
    time_d      = time_q;
    homes_d     = homes_q;
    respawn_d   = 1'b0;
    score_clr_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_edge) begin
          state_d     = ST_PLAY;
          lives_d     = c_LIVES_INIT;
          level_d     = 3'd1;
          time_d      = c_TIME_INIT;
          homes_d     = '0;
          respawn_d   = 1'b1;
          score_clr_d = 1'b1;
        end
      end

      ST_PLAY: begin
        if (sec_tick) begin
          time_d = time_dec;
        end
        // Death outranks a home scored in the same cycle.
        if (death) begin
          state_d = ST_DEATH;
          lives_d = (lives_q != 2'd0) ? (lives_q - 2'd1) : lives_q;
        end else if (i_Home_Pulse) begin
          time_d    = c_TIME_INIT;
          respawn_d = 1'b1;
          if (homes_inc == c_HOMES_TARGET) begin
            homes_d = '0;
            state_d = ST_LEVEL_UP;
          end else begin
            homes_d = homes_inc;
          end
        end
      end

      ST_DEATH: begin
        if (hold_tick) begin
          if (lives_q == 2'd0) begin
            state_d = ST_GAME_OVER;
          end else begin
            state_d   = ST_PLAY;
            time_d    = c_TIME_INIT;
            respawn_d = 1'b1;
          end
        end
      end

      ST_LEVEL_UP: begin
        if (hold_tick) begin
          state_d = ST_PLAY;
          time_d  = c_TIME_INIT;
          level_d = (level_q >= c_LEVEL_MAX) ? c_LEVEL_MAX : (level_q + 3'd1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobes are single-cycle; a request right after a pulse is dropped.
    respawn_d   = respawn_d && !respawn_q;
    score_clr_d = score_clr_d && !score_clr_q;
    play_en_d   = (state_d == ST_PLAY);
  end

  // State, counters, strobes and start-edge sampler.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q     <= ST_IDLE;
      lives_q     <= c_LIVES_INIT;
      level_q     <= 3'd1;
      time_q      <= c_TIME_INIT;
      homes_q     <= '0;
      respawn_q   <= 1'b0;
      score_clr_q <= 1'b0;
      play_en_q   <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      time_q      <= time_d;
      homes_q     <= homes_d;
      respawn_q   <= respawn_d;
      score_clr_q <= score_clr_d;
      play_en_q   <= play_en_d;
      start_q     <= i_Start;
    end
  end

  assign o_Game_State  = state_q;
  assign o_Play_En     = play_en_q;
  assign o_Respawn     = respawn_q;
  assign o_Score_Clear = score_clr_q;
  assign o_Lives       = lives_q;
  assign o_Level       = level_q;
  assign o_Time_Left   = time_q;

endmodule

// File: tb/tb_frogger_game_fsm.sv
// Bench for frogger_game_fsm: vector table, directed game scenarios and a
// randomized run, all against a cycle-level model of the game rules.
module tb_frogger_game_fsm;

  localparam int N     = 10;  // clocks per second
  localparam int HOLD  = 4;
  localparam int ROUND = 3;
  localparam int LIVES = 3;
  localparam int HOMES = 5;
  localparam int MAXL  = 7;

  logic       clk = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_Start = 1'b0;
  logic       i_Collided = 1'b0;
  logic       i_Home_Pulse = 1'b0;
  logic [2:0] o_Game_State;
  logic       o_Play_En;
  logic       o_Respawn;
  logic       o_Score_Clear;
  logic [1:0] o_Lives;
  logic [2:0] o_Level;
  logic [6:0] o_Time_Left;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frogger_game_fsm #(
    .c_CLKS_PER_SEC    (N),
    .c_START_LIVES     (LIVES),
    .c_ROUND_SECONDS   (ROUND),
    .c_HOLD_CLKS       (HOLD),
    .c_HOMES_PER_LEVEL (HOMES),
    .c_MAX_LEVEL       (MAXL)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_L       (i_Rst_L),
    .i_Start       (i_Start),
    .i_Collided    (i_Collided),
    .i_Home_Pulse  (i_Home_Pulse),
    .o_Game_State  (o_Game_State),
    .o_Play_En     (o_Play_En),
    .o_Respawn     (o_Respawn),
    .o_Score_Clear (o_Score_Clear),
    .o_Lives       (o_Lives),
    .o_Level       (o_Level),
    .o_Time_Left   (o_Time_Left)
  );

  // ---------------- reference model ----------------
  // States: 0 idle, 1 play, 2 death, 3 level-up, 4 game over.
  int m_st, m_lives, m_level, m_time, m_homes, m_cycles_in;
  int m_resp, m_sc;
  bit m_prev_start;

  task automatic model_reset();
    m_st = 0; m_lives = LIVES; m_level = 1; m_time = ROUND; m_homes = 0;
    m_cycles_in = 0; m_resp = 0; m_sc = 0; m_prev_start = 0;
  endtask

  task automatic model_step(input logic s, input logic c, input logic h);
    bit edge_seen, second_done, hold_done;
    int nst, resp, sc;
    edge_seen = s && !m_prev_start;
    m_prev_start = s;
    nst = m_st; resp = 0; sc = 0;
    // A second elapses every N cycles spent continuously in play.
    second_done = (m_st == 1) && ((m_cycles_in % N) == N - 1);
    hold_done   = (m_cycles_in == HOLD - 1);
    if (m_st == 0 || m_st == 4) begin
      if (edge_seen) begin
        nst = 1; m_lives = LIVES; m_level = 1; m_time = ROUND; m_homes = 0;
        resp = 1; sc = 1;
      end
    end else if (m_st == 1) begin
      bit timeout;
      timeout = second_done && (m_time == 1);
      if (second_done && m_time > 0) m_time = m_time - 1;
      if (c || timeout) begin
        nst = 2;
        if (m_lives > 0) m_lives = m_lives - 1;
      end else if (h) begin
        m_time = ROUND; resp = 1; m_homes = m_homes + 1;
        if (m_homes == HOMES) begin
          m_homes = 0; nst = 3;
        end
      end
    end else if (m_st == 2) begin
      if (hold_done) begin
        if (m_lives == 0) nst = 4;
        else begin nst = 1; resp = 1; m_time = ROUND; end
      end
    end else if (m_st == 3) begin
      if (hold_done) begin
        nst = 1; m_time = ROUND;
        if (m_level < MAXL) m_level = m_level + 1;
      end
    end
    if (resp == 1 && m_resp == 1) resp = 0;
    if (sc == 1 && m_sc == 1) sc = 0;
    if (nst != m_st) m_cycles_in = 0;
    else m_cycles_in = m_cycles_in + 1;
    m_st = nst; m_resp = resp; m_sc = sc;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("model_state", int'(o_Game_State), m_st);
    chk("model_play_en", int'(o_Play_En), (m_st == 1) ? 1 : 0);
    chk("model_respawn", int'(o_Respawn), m_resp);
    chk("model_score_clear", int'(o_Score_Clear), m_sc);
    chk("model_lives", int'(o_Lives), m_lives);
    chk("model_level", int'(o_Level), m_level);
    chk("model_time", int'(o_Time_Left), m_time);
  endtask

  // Apply one cycle of inputs, advance the model at the edge, compare after.
  task automatic cycle(input logic s, input logic c, input logic h);
    i_Start = s; i_Collided = c; i_Home_Pulse = h;
    @(posedge clk);
    if (!i_Rst_L) model_reset();
    else model_step(s, c, h);
    #1;
    chk_model();
  endtask

  task automatic do_reset();
    i_Rst_L = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    i_Rst_L = 1'b1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"}, int'(o_Game_State), 0);
    chk({tag, "_play_en"}, int'(o_Play_En), 0);
    chk({tag, "_respawn"}, int'(o_Respawn), 0);
    chk({tag, "_score_clear"}, int'(o_Score_Clear), 0);
    chk({tag, "_lives"}, int'(o_Lives), LIVES);
    chk({tag, "_level"}, int'(o_Level), 1);
    chk({tag, "_time"}, int'(o_Time_Left), ROUND);
  endtask

  typedef struct {
    logic s, c, h;
    int   st, lives, level, tm, resp, sc, pe;
  } vec_t;

  vec_t vecs[11];
  logic rs;

  initial begin
    // inputs: start, collide, home | expected: state lives level time resp sc play_en
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 0, 3, 1, 3, 0, 0, 0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1, 3, 1, 3, 1, 1, 1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1, 3, 1, 3, 0, 0, 1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 2, 2, 1, 3, 0, 0, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 2, 2, 1, 3, 0, 0, 0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 2, 2, 1, 3, 0, 0, 0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 2, 2, 1, 3, 0, 0, 0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1, 2, 1, 3, 1, 0, 1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1, 2, 1, 3, 0, 0, 1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1, 2, 1, 3, 1, 0, 1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 2, 1, 1, 3, 0, 0, 0};

    model_reset();
    @(posedge clk); #1;
    do_reset();
    chk_reset_values("reset");

    // Vector table
    for (int i = 0; i < 11; i++) begin
      cycle(vecs[i].s, vecs[i].c, vecs[i].h);
      chk($sformatf("vec%0d_state", i), int'(o_Game_State), vecs[i].st);
      chk($sformatf("vec%0d_lives", i), int'(o_Lives), vecs[i].lives);
      chk($sformatf("vec%0d_level", i), int'(o_Level), vecs[i].level);
      chk($sformatf("vec%0d_time", i), int'(o_Time_Left), vecs[i].tm);
      chk($sformatf("vec%0d_respawn", i), int'(o_Respawn), vecs[i].resp);
      chk($sformatf("vec%0d_score_clear", i), int'(o_Score_Clear), vecs[i].sc);
      chk($sformatf("vec%0d_play_en", i), int'(o_Play_En), vecs[i].pe);
    end

    // Round timer runs out with no events
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("timer_after_1s", int'(o_Time_Left), 2);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("timer_after_2s", int'(o_Time_Left), 1);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("timeout_state", int'(o_Game_State), 2);
    chk("timeout_lives", int'(o_Lives), 2);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("timeout_hold_state", int'(o_Game_State), 2);
    cycle(1'b1, 1'b0, 1'b0);
    chk("timeout_exit_state", int'(o_Game_State), 1);
    chk("timeout_exit_time", int'(o_Time_Left), ROUND);
    chk("timeout_exit_respawn", int'(o_Respawn), 1);

    // Three collisions to game over, then restart
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 1'b0);
      chk($sformatf("collide%0d_lives", k), int'(o_Lives), 2 - k);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    end
    chk("gameover_state", int'(o_Game_State), 4);
    chk("gameover_play_en", int'(o_Play_En), 0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1);
    chk("gameover_frozen_state", int'(o_Game_State), 4);
    chk("gameover_frozen_lives", int'(o_Lives), 0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("restart_state", int'(o_Game_State), 1);
    chk("restart_lives", int'(o_Lives), LIVES);
    chk("restart_level", int'(o_Level), 1);
    chk("restart_score_clear", int'(o_Score_Clear), 1);

    // Homes drive level-ups up to saturation
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    for (int lv = 1; lv <= 7; lv++) begin
      cycle(1'b1, 1'b0, 1'b0);
      for (int j = 0; j < HOMES; j++) begin
        cycle(1'b1, 1'b0, 1'b1);
        chk($sformatf("lv%0d_home%0d_respawn", lv, j), int'(o_Respawn), 1);
        if (j < HOMES - 1) cycle(1'b1, 1'b0, 1'b0);
      end
      chk($sformatf("lv%0d_levelup_state", lv), int'(o_Game_State), 3);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
      chk($sformatf("lv%0d_play_state", lv), int'(o_Game_State), 1);
      chk($sformatf("lv%0d_level", lv), int'(o_Level), (lv + 1 > MAXL) ? MAXL : lv + 1);
    end

    // Collision and home together: death wins, home not counted
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    chk("both_state", int'(o_Game_State), 2);
    chk("both_lives", int'(o_Lives), 2);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0);
    end
    chk("both_homes3_state", int'(o_Game_State), 1);
    cycle(1'b1, 1'b0, 1'b1);
    chk("both_homes4_state", int'(o_Game_State), 3);

    // Reset in the middle of a death hold
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    do_reset();
    chk_reset_values("midhold_reset");

    // Randomized play against the model
    rs = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 99) < 4) rs = ~rs;
        cycle(rs, ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
